wb_stage: RTL

Parametrised writeback stage for the pipelined core. It registers one retiring instruction and selects its result from ALU, LSU or CSR data. It writes the GPR file on a commit handshake and serves combinational read ports to the decode stage with same-cycle write bypass. It also keeps a per-register pending-write scoreboard so decode can stall on RAW hazards with several writes in flight.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_stage_gpr_file.sv | 54 +++++
 rtl/wb_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback stage and its GPR file.
package wb_pkg;

    typedef enum logic [1:0] {
        RD_ALU = 2'd0,
        RD_LSU = 2'd1,
        RD_CSR = 2'd2,
        RD_RSV = 2'd3
    } rd_sel_e;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned NR_REGS_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 2;

    typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

endpackage

// File: rtl/wb_stage_gpr_file.sv
// General-purpose register file with hardwired x0 and per-port bypass of the
// write happening in the same cycle.
module gpr_file #(
    parameter  int unsigned XLEN      = 32,
    parameter  int unsigned NR_REGS   = 32,
    parameter  int unsigned NR_RPORTS = 2,
    localparam int unsigned AW        = $clog2(NR_REGS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [AW-1:0]                       wr_addr,
    input  logic [XLEN-1:0]                     wr_data,
    input  logic [NR_RPORTS-1:0][AW-1:0]        rd_addr,
    output logic [NR_RPORTS-1:0][XLEN-1:0]      rd_data
);

    logic [XLEN-1:0] gpr_q [NR_REGS];
    logic [XLEN-1:0] gpr_d [NR_REGS];
    logic            wr_live;

    assign wr_live = wr_en & (wr_addr != '0);

    always_comb begin
        gpr_d = gpr_q;
        if (wr_live) begin
            gpr_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR_REGS; r++) begin
                gpr_q[r] <= '0;
            end
        end else begin
            gpr_q <= gpr_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NR_RPORTS; i++) begin
            if (rd_addr[i] == '0) begin
                rd_data[i] = '0;
            end else if (wr_live && (wr_addr == rd_addr[i])) begin
                rd_data[i] = wr_data;
            end else begin
                rd_data[i] = gpr_q[rd_addr[i]];
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select register, commit handshake, GPR write and
// a per-register pending-write scoreboard for decode RAW stalls.
module wb_stage
    import wb_pkg::*;
#(
    parameter  int unsigned XLEN      = XLEN_DEF,
    parameter  int unsigned NR_REGS   = NR_REGS_DEF,
    parameter  int unsigned NR_RPORTS = 2,
    parameter  int unsigned CNT_W     = CNT_W_DEF,
    localparam int unsigned AW        = $clog2(NR_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [XLEN-1:0]                in_alu,
    input  logic [XLEN-1:0]                in_lsu_rdata,
    input  logic [XLEN-1:0]                in_csr_rdata,
    input  rd_sel_e                        in_rd_sel,
    input  logic                           in_rd_wen,
    input  logic [AW-1:0]                  in_rd_addr,
    output logic                           commit_valid,
    input  logic                           commit_ready,
    output logic                           commit_rd_wen,
    output logic [AW-1:0]                  commit_rd_addr,
    output logic [XLEN-1:0]                commit_rd_data,
    input  logic [NR_RPORTS-1:0][AW-1:0]   rs_addr,
    output logic [NR_RPORTS-1:0][XLEN-1:0] rs_data,
    output logic [NR_RPORTS-1:0]           rs_busy,
    input  logic                           iss_valid,
    input  logic                           iss_rd_wen,
    input  logic [AW-1:0]                  iss_rd_addr,
    output logic                           sb_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            wb_valid_q, wb_valid_d;
    logic            rd_wen_q,   rd_wen_d;
    logic [AW-1:0]   rd_addr_q,  rd_addr_d;
    logic [XLEN-1:0] rd_data_q,  rd_data_d;
    logic            ovf_q,      ovf_d;
    logic [CNT_W-1:0] cnt_q [NR_REGS];
    logic [CNT_W-1:0] cnt_d [NR_REGS];
    logic [NR_REGS-1:0] sb_inc, sb_dec;
    logic            fire, accept, wr_en;

    assign fire     = wb_valid_q & commit_ready;
    assign in_ready = ~wb_valid_q | commit_ready;
    assign accept   = in_valid & in_ready;
    assign wr_en    = fire & rd_wen_q & (rd_addr_q != '0);

    always_comb begin
        wb_valid_d = wb_valid_q;
        rd_wen_d   = rd_wen_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        if (accept) begin
            wb_valid_d = 1'b1;
            rd_wen_d   = in_rd_wen;
            rd_addr_d  = in_rd_addr;
            case (in_rd_sel)
                RD_LSU:  rd_data_d = in_lsu_rdata;
                RD_CSR:  rd_data_d = in_csr_rdata;
                default: rd_data_d = in_alu;
            endcase
        end else if (fire) begin
            wb_valid_d = 1'b0;
        end
    end

    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        for (int r = 1; r < NR_REGS; r++) begin
            sb_inc[r] = iss_valid & iss_rd_wen & (iss_rd_addr == AW'(r));
            sb_dec[r] = wr_en & (rd_addr_q == AW'(r));
        end
    end

    // Simultaneous issue and retire on one register cancel out, including at saturation.
    always_comb begin
        ovf_d    = ovf_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NR_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (sb_inc[r] && !sb_dec[r]) begin
                if (cnt_q[r] == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
            end else if (sb_dec[r] && !sb_inc[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    // A retiring last write releases the stall in its own fire cycle.
    always_comb begin
        rs_busy = '0;
        for (int i = 0; i < NR_RPORTS; i++) begin
            rs_busy[i] = (rs_addr[i] != '0) && (cnt_q[rs_addr[i]] != '0) &&
                         !(sb_dec[rs_addr[i]] && (cnt_q[rs_addr[i]] == CNT_ONE));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            rd_wen_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            for (int r = 0; r < NR_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            wb_valid_q <= wb_valid_d;
            rd_wen_q   <= rd_wen_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign commit_valid   = wb_valid_q;
    assign commit_rd_wen  = rd_wen_q;
    assign commit_rd_addr = rd_addr_q;
    assign commit_rd_data = rd_data_q;
    assign sb_overflow    = ovf_q;

    gpr_file #(
        .XLEN      (XLEN),
        .NR_REGS   (NR_REGS),
        .NR_RPORTS (NR_RPORTS)
    ) u_gpr_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (rd_addr_q),
        .wr_data (rd_data_q),
        .rd_addr (rs_addr),
        .rd_data (rs_data)
    );

endmodule
